// File: rtl/key_conditioner_if.sv
// Key conditioner port bundle: raw keys in, clean pulses/levels out.
// Latency: n/a (signal bundle only).
// Backpressure: none; keys are free-running and cannot be stalled.
//   nkey  : raw active-low keys (driven by the board side)
//   press : one-cycle press / auto-repeat pulses
//   level : debounced pressed level
//   tick  : debounce sample strobe (debug)
interface key_conditioner_if #(
  parameter int W = 7
);
  logic [W-1:0] nkey;
  logic [W-1:0] press;
  logic [W-1:0] level;
  logic         tick;

  modport master (output nkey, input press, level, tick);
  modport slave  (input nkey, output press, level, tick);
endinterface

// File: rtl/key_conditioner.sv
// Syncs, debounces and edge-detects W bouncing active-low keys into press pulses.
// Latency: 2-clk sync + STABLE sample ticks to level, press one clock after level rises.
// Backpressure: none; pulses are fire-and-forget, several keys may pulse together.
//   clk, rst  : core clock, async active-high reset
//   kif.slave : nkey in; press, level, tick out (all outputs registered or
//               decoded from registers, no path from nkey)
module key_conditioner #(
  parameter int           W          = 7,
  parameter int           TICK_DIV   = 500000,
  parameter int           STABLE     = 4,
  parameter logic [W-1:0] REP_MASK   = '0,
  parameter int           REP_DELAY  = 50,
  parameter int           REP_PERIOD = 10
) (
  input logic              clk,
  input logic              rst,
  key_conditioner_if.slave kif
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE + 1);
  localparam int RW = $clog2(REP_DELAY + 1);

  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] STABLE_C   = CW'(STABLE);
  // The repeat counter never actually holds REP_DELAY: the tick that would
  // take it there fires the pulse and reloads instead.
  localparam logic [RW-1:0] REP_LAST   = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REP_DELAY - REP_PERIOD);

  logic [PW-1:0] pcnt;
  logic          tick;
  logic [W-1:0]  sync1, sync2, p;
  logic [W-1:0]  cand, cand_nx;
  logic [W-1:0]  level, level_nx, level_d;
  logic [W-1:0]  press, press_nx;
  logic [CW-1:0] cnt    [W];
  logic [CW-1:0] cnt_nx [W];
  logic [RW-1:0] rep    [W];
  logic [RW-1:0] rep_nx [W];

  assign tick      = (pcnt == TICK_LAST);
  assign p         = ~sync2;
  assign kif.tick  = tick;
  assign kif.press = press;
  assign kif.level = level;

  always_comb begin
    cand_nx  = cand;
    level_nx = level;
    cnt_nx   = cnt;
    rep_nx   = rep;
    // Rising edge of the registered level, so the pulse lands the cycle after.
    press_nx = level & ~level_d;
    for (int i = 0; i < W; i++) begin
      if (tick) begin
        if (p[i] == cand[i]) begin
          if (cnt[i] != STABLE_C) cnt_nx[i] = cnt[i] + CW'(1);
        end else begin
          cand_nx[i] = p[i];
          cnt_nx[i]  = CW'(1);
        end
        if ((cnt_nx[i] == STABLE_C) && (cand_nx[i] != level[i]))
          level_nx[i] = cand_nx[i];
      end
      // Repeat counting uses the level in force during the tick, so the tick
      // that raises level does not count toward the first repeat.
      if (!REP_MASK[i] || !level[i]) begin
        rep_nx[i] = '0;
      end else if (tick) begin
        if (rep[i] == REP_LAST) begin
          rep_nx[i]   = REP_RELOAD;
          press_nx[i] = 1'b1;
        end else begin
          rep_nx[i] = rep[i] + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt    <= '0;
      sync1   <= '1;
      sync2   <= '1;
      cand    <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= '0;
        rep[i] <= '0;
      end
    end else begin
      pcnt    <= tick ? '0 : pcnt + PW'(1);
      sync1   <= kif.nkey;
      sync2   <= sync1;
      cand    <= cand_nx;
      level   <= level_nx;
      level_d <= level;
      press   <= press_nx;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= cnt_nx[i];
        rep[i] <= rep_nx[i];
      end
    end
  end
endmodule
